// File: rtl/hex_word_decoder_if.sv
// ---------------------------------------------------------------------------
// hex_word_decoder_if
//  Bundles the four 7-segment digit buses seen by the decoder together with
//  the decoded word/rotation results it reports back.
//  master : the display side (drives i_HEX*, observes the decoded results)
//  slave  : the decoder (reads i_HEX*, drives o_*)
//  Signals:
//   i_HEX0..i_HEX3  7-bit active-low digits {g,f,e,d,c,b,a}, HEX3 leftmost
//   o_word          committed word code
//   o_rot           committed rotation
//   o_valid         a word has been committed since reset
//   o_changed       one-cycle pulse on a commit that alters {o_word,o_rot}
//   o_err_cnt       saturating count of UNKNOWN commits
// ---------------------------------------------------------------------------
interface hex_word_decoder_if #(
  parameter int ERR_W = 8
);
  logic [6:0]       i_HEX0;
  logic [6:0]       i_HEX1;
  logic [6:0]       i_HEX2;
  logic [6:0]       i_HEX3;
  logic [2:0]       o_word;
  logic [1:0]       o_rot;
  logic             o_valid;
  logic             o_changed;
  logic [ERR_W-1:0] o_err_cnt;

  modport master (
    output i_HEX0, i_HEX1, i_HEX2, i_HEX3,
    input  o_word, o_rot, o_valid, o_changed, o_err_cnt
  );

  modport slave (
    input  i_HEX0, i_HEX1, i_HEX2, i_HEX3,
    output o_word, o_rot, o_valid, o_changed, o_err_cnt
  );
endinterface

// File: rtl/hex_word_decoder.sv
// ---------------------------------------------------------------------------
// hex_word_decoder
//  Loopback monitor for the EASY/FPGA display state machine. Registers the
//  four digit buses, classifies the 28-bit pattern as OFF, EASY, FPGA,
//  EASY_SHIFT, FPGA_SHIFT or UNKNOWN (with rotation), and commits a
//  classification only after it has been seen STABLE_CYCLES clocks in a row.
//  Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    hex_word_decoder_if.slave (digit inputs, decoded outputs)
// ---------------------------------------------------------------------------
module hex_word_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hex_word_decoder_if.slave      bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [2:0] CODE_OFF      = 3'd0;
  localparam logic [2:0] CODE_EASY     = 3'd1;
  localparam logic [2:0] CODE_FPGA     = 3'd2;
  localparam logic [2:0] CODE_EASY_SH  = 3'd3;
  localparam logic [2:0] CODE_FPGA_SH  = 3'd4;
  localparam logic [2:0] CODE_NONE     = 3'd6;  // never produced by the classifier
  localparam logic [2:0] CODE_UNKNOWN  = 3'd7;

  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_S     = 7'b0010010;
  localparam logic [6:0] GLYPH_Y     = 7'b0010001;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_P     = 7'b0001100;
  localparam logic [6:0] GLYPH_G     = 7'b1000010;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [27:0] WORD_EASY = {GLYPH_E, GLYPH_A, GLYPH_S, GLYPH_Y};
  localparam logic [27:0] WORD_FPGA = {GLYPH_F, GLYPH_P, GLYPH_G, GLYPH_A};
  localparam logic [27:0] WORD_OFF  = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  // Rotating right by k digits moves the HEX3 letter to HEX(3-k).
  function automatic logic [27:0] rot_f(input logic [27:0] w, input logic [1:0] k);
    logic [27:0] r;
    case (k)
      2'd0:    r = w;
      2'd1:    r = {w[6:0],  w[27:7]};
      2'd2:    r = {w[13:0], w[27:14]};
      2'd3:    r = {w[20:0], w[27:21]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Exact 28-bit match against every legal word/rotation; anything else is UNKNOWN.
  function automatic logic [4:0] classify_f(input logic [27:0] hex);
    logic [4:0] res;
    res = {CODE_UNKNOWN, 2'd0};
    if (hex == WORD_OFF) begin
      res = {CODE_OFF, 2'd0};
    end
    for (int k = 0; k < 4; k++) begin
      if (hex == rot_f(WORD_EASY, 2'(k))) begin
        res = {((k == 0) ? CODE_EASY : CODE_EASY_SH), 2'(k)};
      end
      if (hex == rot_f(WORD_FPGA, 2'(k))) begin
        res = {((k == 0) ? CODE_FPGA : CODE_FPGA_SH), 2'(k)};
      end
    end
    return res;
  endfunction

  logic [27:0]      s_hex_r;
  logic [4:0]       cand_s;
  logic [4:0]       cand_q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             same_s;
  logic             commit_s;
  logic             diff_s;
  state_e           state_r;
  state_e           state_nxt_s;
  logic [2:0]       word_r;
  logic [1:0]       rot_r;
  logic             changed_r;
  logic [ERR_W-1:0] err_cnt_r;

  // Input register stage breaking the path from the display logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_hex_r <= WORD_OFF;
    end else begin
      s_hex_r <= {bus.i_HEX3, bus.i_HEX2, bus.i_HEX1, bus.i_HEX0};
    end
  end

  // Classification of the registered pattern.
  always_comb begin
    cand_s = classify_f(s_hex_r);
  end

  // Stability tracking: commit exactly when the count first reaches STABLE_CYCLES.
  always_comb begin
    same_s    = (cand_s == cand_q_r);
    commit_s  = 1'b0;
    cnt_nxt_s = cnt_r;
    if (same_s) begin
      if (cnt_r < CNT_W'(STABLE_CYCLES)) begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
        commit_s  = (cnt_r == CNT_W'(STABLE_CYCLES - 1));
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = CNT_W'(1);
      commit_s  = (STABLE_CYCLES == 1);
    end
    diff_s = (cand_s != {word_r, rot_r}) || (state_r == ST_IDLE);
  end

  // Candidate and stability counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q_r <= {CODE_NONE, 2'd0};
      cnt_r    <= '0;
    end else begin
      cand_q_r <= cand_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  // Validity FSM next state: leaves IDLE on the first commit, never returns.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (commit_s) begin
          state_nxt_s = ST_TRACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TRACK: state_nxt_s = ST_TRACK;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Validity FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Committed outputs, change pulse and saturating UNKNOWN counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r    <= CODE_OFF;
      rot_r     <= 2'd0;
      changed_r <= 1'b0;
      err_cnt_r <= '0;
    end else if (commit_s) begin
      word_r    <= cand_s[4:2];
      rot_r     <= cand_s[1:0];
      changed_r <= diff_s;
      if ((cand_s[4:2] == CODE_UNKNOWN) && (err_cnt_r != {ERR_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + ERR_W'(1);
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end else begin
      changed_r <= 1'b0;
    end
  end

  assign bus.o_word    = word_r;
  assign bus.o_rot     = rot_r;
  assign bus.o_valid   = (state_r == ST_TRACK);
  assign bus.o_changed = changed_r;
  assign bus.o_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_hex_word_decoder.sv
module tb_hex_word_decoder;

  localparam logic [6:0] E = 7'b0000110;
  localparam logic [6:0] A = 7'b0001000;
  localparam logic [6:0] S = 7'b0010010;
  localparam logic [6:0] Y = 7'b0010001;
  localparam logic [6:0] F = 7'b0001110;
  localparam logic [6:0] P = 7'b0001100;
  localparam logic [6:0] G = 7'b1000010;
  localparam logic [6:0] B = 7'b1111111;

  typedef struct {
    logic [2:0] word;
    logic [1:0] rot;
    int         err;
    int         cyc;   // expected commit edge; -1 = any
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   n_pulses;
  exp_t sb_q[$];

  // bench-side model of the held result
  logic [2:0] m_word;
  logic [1:0] m_rot;
  logic       m_valid;
  int         m_err;

  hex_word_decoder_if #(.ERR_W(8)) bus ();

  hex_word_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard on every o_changed pulse.
  always @(negedge clk) begin
    if (rst_n && bus.o_changed) begin
      exp_t e;
      n_pulses++;
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("word", int'(bus.o_word), int'(e.word));
        check("rot", int'(bus.o_rot), int'(e.rot));
        check("err_cnt", int'(bus.o_err_cnt), e.err);
        check("valid", int'(bus.o_valid), 1);
        if (e.cyc >= 0) check("latency_edge", cyc, e.cyc);
      end
    end
  end

  task automatic set_hex(input logic [6:0] h3, h2, h1, h0);
    bus.i_HEX3 = h3; bus.i_HEX2 = h2; bus.i_HEX1 = h1; bus.i_HEX0 = h0;
  endtask

  // Called at a negedge: drive a pattern, predict its commit 5 edges later.
  task automatic apply(input logic [6:0] h3, h2, h1, h0,
                       input logic [2:0] w, input logic [1:0] r, input int hold);
    exp_t e;
    set_hex(h3, h2, h1, h0);
    if (w == 3'd7 && m_err < 255) m_err++;
    if (!m_valid || w != m_word || r != m_rot) begin
      e.word = w; e.rot = r; e.err = m_err; e.cyc = cyc + 5;
      sb_q.push_back(e);
    end
    m_word = w; m_rot = r; m_valid = 1'b1;
    repeat (hold) @(negedge clk);
  endtask

  task automatic model_reset();
    m_word = 3'd0; m_rot = 2'd0; m_valid = 1'b0; m_err = 0;
    sb_q.delete();
  endtask

  initial begin
    int p0;
    exp_t e;
    cyc = 0; n_checks = 0; n_pass = 0; n_pulses = 0;
    model_reset();
    rst_n = 1'b0;
    set_hex(B, B, B, B);
    #23;
    check("rst_word", int'(bus.o_word), 0);
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_changed", int'(bus.o_changed), 0);
    check("rst_err", int'(bus.o_err_cnt), 0);

    // release with blanks held: OFF commits shortly after
    @(negedge clk);
    rst_n = 1'b1;
    e.word = 3'd0; e.rot = 2'd0; e.err = 0; e.cyc = -1;
    sb_q.push_back(e);
    m_valid = 1'b1;
    repeat (8) @(negedge clk);
    check("off_committed", sb_q.size(), 0);

    // EASY, then a long hold with no further pulse
    apply(E, A, S, Y, 3'd1, 2'd0, 6);
    p0 = n_pulses;
    repeat (100) @(negedge clk);
    check("hold_no_pulse", n_pulses - p0, 0);

    // rotations
    apply(P, G, A, F, 3'd4, 2'd3, 6);   // F at HEX0 -> k=3
    apply(Y, E, A, S, 3'd3, 2'd1, 6);   // E at HEX2 -> k=1
    apply(A, F, P, G, 3'd4, 2'd1, 6);   // F at HEX2 -> k=1
    apply(S, Y, E, A, 3'd3, 2'd2, 6);   // E at HEX1 -> k=2
    apply(F, P, G, A, 3'd2, 2'd0, 6);

    // 3-clock glitch of EASY while FPGA is held
    p0 = n_pulses;
    set_hex(E, A, S, Y);
    repeat (3) @(negedge clk);
    set_hex(F, P, G, A);
    repeat (10) @(negedge clk);
    check("glitch_no_pulse", n_pulses - p0, 0);
    check("glitch_word", int'(bus.o_word), 2);
    check("glitch_rot", int'(bus.o_rot), 0);

    // UNKNOWN/OFF alternation drives the error counter to saturation
    for (int i = 0; i < 300; i++) begin
      apply(E, E, E, E, 3'd7, 2'd0, 5);
      apply(B, B, B, B, 3'd0, 2'd0, 5);
    end
    repeat (3) @(negedge clk);
    check("err_saturated", int'(bus.o_err_cnt), 255);

    // reset in the middle of an FPGA count
    set_hex(F, P, G, A);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_word", int'(bus.o_word), 0);
    check("midrst_valid", int'(bus.o_valid), 0);
    check("midrst_err", int'(bus.o_err_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(F, P, G, A, 3'd2, 2'd0, 8);

    // drain the scoreboard within a bounded time
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
